// File: rtl/seg7_pkg.sv
// Shared types, glyph table and digit-step helper for the scanned 7-segment counter.
package seg7_pkg;

  // One counter digit; MODULUS is at most 16, so a nibble always suffices.
  typedef logic [3:0] digit_t;

  // Hex glyphs, segments {g,f,e,d,c,b,a} with bit0 = a, active-high.
  localparam logic [6:0] Glyphs [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Next value of a digit that is stepping; wraps at both ends of 0..max.
  function automatic digit_t next_digit(input digit_t d, input logic up, input digit_t max);
    digit_t r;
    if (up) begin
      r = (d == max) ? 4'd0 : d + 4'd1;
    end else begin
      r = (d == 4'd0) ? max : d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to 7-segment glyph lookup (active-high segments).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  digit_t     nibble_i,
  output logic [6:0] glyph_o
);

  assign glyph_o = Glyphs[nibble_i];

endmodule

// File: rtl/seg7_mod_counter_scan.sv
// Cascaded modulo up/down counter with a time-multiplexed 7-segment display scanner.
module seg7_mod_counter_scan
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned MODULUS      = 10,
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned COMMON_ANODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  man_sel,
  input  logic [3:0]            man_val,
  output logic [4*N_DIGITS-1:0] count,
  output logic                  carry,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_en
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(N_DIGITS - 1);
  localparam digit_t          DigitMax = digit_t'(MODULUS - 1);

  // XOR masks that apply the pin polarity at the output registers.
  localparam logic [6:0]          SegMask = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] DigMask = (COMMON_ANODE != 0) ? '1 : '0;

  localparam logic [6:0]          SegReset = Glyphs[0] ^ SegMask;
  localparam logic [N_DIGITS-1:0] DigReset = N_DIGITS'(1) ^ DigMask;

  // ---------------------------------------------------------------------------
  // Counter
  // ---------------------------------------------------------------------------
  logic [4*N_DIGITS-1:0] count_q, count_d;
  logic                  carry_q, carry_d;

  // step[i] is high when digit i advances this cycle; step[N_DIGITS] means full wrap.
  logic [N_DIGITS:0] step;

  assign step[0] = en;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    digit_t cur;
    logic   at_end;

    assign cur    = count_q[4*gi +: 4];
    // A digit passes the step on only when it is about to wrap in the current direction.
    assign at_end = up ? (cur == DigitMax) : (cur == 4'd0);

    assign step[gi+1]          = step[gi] & at_end;
    assign count_d[4*gi +: 4]  = step[gi] ? next_digit(cur, up, DigitMax) : cur;
  end

  // Carry is a one-cycle flag raised on the edge where every digit wraps.
  always_comb begin
    carry_d = step[N_DIGITS];
    if (clr) begin
      carry_d = 1'b0;
    end
  end

  // Counter register: rst and clr both clear; otherwise take the cascaded next value.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;

  // ---------------------------------------------------------------------------
  // Scan sequencer
  // ---------------------------------------------------------------------------
  logic [DivW-1:0] div_q;
  logic [IdxW-1:0] idx_q;

  // Divider dwells SCAN_DIV cycles per position, then advances the digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
      idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display path
  // ---------------------------------------------------------------------------
  digit_t              shown;
  logic [6:0]          glyph;
  logic [N_DIGITS-1:0] dig_sel;

  // Select the nibble for the current position, or the manual override.
  always_comb begin
    shown = count_q[3:0];
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        shown = count_q[4*i +: 4];
      end
    end
    if (man_sel) begin
      shown = man_val;
    end
  end

  assign dig_sel = N_DIGITS'(1) << idx_q;

  seg7_hex_decode u_decode (
    .nibble_i (shown),
    .glyph_o  (glyph)
  );

  logic [6:0]          seg_q;
  logic [N_DIGITS-1:0] dig_en_q;

  // Output registers with pin polarity folded in.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= SegReset;
      dig_en_q <= DigReset;
    end else begin
      seg_q    <= glyph ^ SegMask;
      dig_en_q <= dig_sel ^ DigMask;
    end
  end

  assign seg    = seg_q;
  assign dig_en = dig_en_q;

endmodule

// File: tb/tb_seg7_mod_counter_scan.sv
// Self-checking bench: literal vector table, directed corner sequences and a random run
// compared against an arithmetic reference model.
module tb_seg7_mod_counter_scan;

  localparam int unsigned ND    = 2;
  localparam int unsigned MOD   = 10;
  localparam int unsigned SD    = 4;
  localparam int unsigned Total = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, clr, man_sel;
  logic [3:0] man_val;
  logic [7:0] count, count_ca;
  logic       carry, carry_ca;
  logic [6:0] seg, seg_ca;
  logic [1:0] dig_en, dig_en_ca;

  seg7_mod_counter_scan #(
    .N_DIGITS(ND), .MODULUS(MOD), .SCAN_DIV(SD), .COMMON_ANODE(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .man_sel(man_sel),
    .man_val(man_val), .count(count), .carry(carry), .seg(seg), .dig_en(dig_en)
  );

  seg7_mod_counter_scan #(
    .N_DIGITS(ND), .MODULUS(MOD), .SCAN_DIV(SD), .COMMON_ANODE(1)
  ) dut_ca (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .man_sel(man_sel),
    .man_val(man_val), .count(count_ca), .carry(carry_ca), .seg(seg_ca),
    .dig_en(dig_en_ca)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph_tab [16];

  // Reference model: the count is one integer modulo MOD**ND; the scan position is
  // derived from the number of cycles since reset.
  int         m_val;
  int         m_t;
  logic       m_carry;
  logic [6:0] m_seg;
  logic [1:0] m_dig;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int digit_of(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * MOD;
    return (v / p) % MOD;
  endfunction

  function automatic logic [7:0] packed_count(input int v);
    logic [7:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(digit_of(v, i));
    return r;
  endfunction

  task automatic model_step(input logic r, e, u, c, ms, input logic [3:0] mv);
    int         idx;
    logic [3:0] shown;
    if (r) begin
      m_val = 0; m_carry = 1'b0; m_t = 0; m_seg = glyph_tab[0]; m_dig = 2'b01;
    end else begin
      idx   = (m_t / SD) % ND;
      shown = ms ? mv : 4'(digit_of(m_val, idx));
      m_seg = glyph_tab[shown];
      m_dig = 2'(1 << idx);
      m_t++;
      if (c) begin
        m_val = 0; m_carry = 1'b0;
      end else if (e && u) begin
        m_carry = (m_val == Total - 1);
        m_val   = (m_val + 1) % Total;
      end else if (e) begin
        m_carry = (m_val == 0);
        m_val   = (m_val + Total - 1) % Total;
      end else begin
        m_carry = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [6:0] inv_seg;
    logic [1:0] inv_dig;
    inv_seg = ~m_seg;
    inv_dig = ~m_dig;
    chk("count",     count,     packed_count(m_val));
    chk("carry",     carry,     m_carry);
    chk("seg",       seg,       m_seg);
    chk("dig_en",    dig_en,    m_dig);
    chk("ca_count",  count_ca,  packed_count(m_val));
    chk("ca_seg",    seg_ca,    inv_seg);
    chk("ca_dig_en", dig_en_ca, inv_dig);
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input logic r, e, u, c, ms, input logic [3:0] mv);
    rst = r; en = e; up = u; clr = c; man_sel = ms; man_val = mv;
    @(posedge clk);
    model_step(r, e, u, c, ms, mv);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic       r, e, u, c, ms;
    logic [3:0] mv;
    logic [7:0] exp_count;
    logic       exp_carry;
  } vec_t;

  vec_t vecs [12];

  int  n01;
  bit  found;

  initial begin
    glyph_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    //          r     e     u     c     ms    mv    count  carry
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h01, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h02, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h01, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h99, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h98, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h98, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'hA, 8'h01, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h02, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0};

    // Reset state.
    tick(1, 0, 0, 0, 0, 4'h0);
    chk("rst_count", count, 8'h00);
    chk("rst_carry", carry, 1'b0);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_dig_en", dig_en, 2'b01);

    // Vector table.
    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].c, vecs[i].ms, vecs[i].mv);
      chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
      chk($sformatf("vec%0d_carry", i), carry, vecs[i].exp_carry);
    end

    // Full up wrap.
    tick(1, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 99; i++) tick(0, 1, 1, 0, 0, 4'h0);
    chk("up99_count", count, 8'h99);
    chk("up99_carry", carry, 1'b0);
    tick(0, 1, 1, 0, 0, 4'h0);
    chk("upwrap_count", count, 8'h00);
    chk("upwrap_carry", carry, 1'b1);
    tick(0, 0, 1, 0, 0, 4'h0);
    chk("upwrap_carry_drop", carry, 1'b0);

    // Down wrap then ten steps.
    tick(0, 1, 0, 0, 0, 4'h0);
    chk("dnwrap_count", count, 8'h99);
    chk("dnwrap_carry", carry, 1'b1);
    for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0, 4'h0);
    chk("dn10_count", count, 8'h89);
    chk("dn10_carry", carry, 1'b0);

    // Scan at 0x37.
    tick(1, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 37; i++) tick(0, 1, 1, 0, 0, 4'h0);
    n01 = 0;
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 0, 0, 0, 4'h0);
      if (dig_en == 2'b01) n01++;
      chk("scan37_seg", seg, (dig_en == 2'b01) ? 7'h07 : 7'h4F);
    end
    chk("scan37_dwell", n01, 8);

    // Manual override while counting.
    for (int i = 0; i < 8; i++) begin
      tick(0, 1, 1, 0, 1, 4'hA);
      chk("man_seg", seg, 7'h77);
    end
    chk("man_count", count, 8'h45);
    for (int i = 0; i < 8; i++) tick(0, 0, 0, 0, 0, 4'h0);

    // clr beats en at 0x58.
    tick(1, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 58; i++) tick(0, 1, 1, 0, 0, 4'h0);
    chk("pre_clr_count", count, 8'h58);
    tick(0, 1, 1, 1, 0, 4'h0);
    chk("clr_count", count, 8'h00);
    chk("clr_carry", carry, 1'b0);

    // Reset mid-scan while position 1 is shown.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(0, 1, 1, 0, 0, 4'h0);
      if (dig_en == 2'b10) found = 1;
    end
    chk("wait_idx1", found, 1'b1);
    tick(1, 1, 1, 0, 0, 4'h0);
    chk("midrst_dig_en", dig_en, 2'b01);
    chk("midrst_count", count, 8'h00);

    // Random run against the model.
    for (int i = 0; i < 2000; i++) begin
      tick(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
           ($urandom_range(15) == 0), ($urandom_range(7) == 0), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
